// File: rtl/vga_frame_sink_if.sv
// vga_frame_sink_if: pixel-write bus from the note-drawing logic into the frame sink.
//   x       : write column
//   y       : write row
//   colour  : {R,G,B} colour bits
//   writeEn : write strobe, one pixel per clk while high
// master = drawer side, slave = frame sink side.
interface vga_frame_sink_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn;

  modport master (output x, y, colour, writeEn);
  modport slave  (input  x, y, colour, writeEn);
endinterface

// File: rtl/vga_frame_sink.sv
// vga_frame_sink: 3-bit-per-pixel framebuffer with a pixel-write port and a
// continuous VGA scan-out, each framebuffer pixel replicated as a
// (1<<SCALE_SHIFT)-square block of screen pixels.
//   clk         : system clock (pixel clock is clk/2)
//   reset       : asynchronous active-low reset
//   wr          : pixel-write bus (slave side)
//   VGA_CLK     : pixel clock to the DAC
//   VGA_HS/VS   : active-low syncs
//   VGA_BLANK_N : high during the visible region
//   VGA_SYNC_N  : tied low
//   VGA_R/G/B   : colour channels, each bit expanded to 8'hFF / 8'h00
//   frame_start : one-clk pulse when the scan counters step to (0,0)
module vga_frame_sink #(
  parameter int unsigned FB_W        = 160,
  parameter int unsigned FB_H        = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned H_VIS       = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VIS       = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33
) (
  input  logic                   clk,
  input  logic                   reset,
  vga_frame_sink_if.slave        wr,
  output logic                   VGA_CLK,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_N,
  output logic                   VGA_SYNC_N,
  output logic [7:0]             VGA_R,
  output logic [7:0]             VGA_G,
  output logic [7:0]             VGA_B,
  output logic                   frame_start
);

  localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W      = $clog2(H_TOTAL);
  localparam int unsigned V_W      = $clog2(V_TOTAL);
  localparam int unsigned FB_DEPTH = FB_W * FB_H;
  localparam int unsigned ADDR_W   = $clog2(FB_DEPTH);
  localparam int unsigned HS_START = H_VIS + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VIS + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Pixel enable and scan counters
  logic             pix_en_q, pix_en_d;
  logic             vga_clk_q;
  logic [H_W-1:0]   h_cnt_q, h_cnt_d;
  logic [V_W-1:0]   v_cnt_q, v_cnt_d;
  logic             frame_start_q, frame_start_d;

  // Decoded scan position
  logic             vis_c;
  logic             hs_c;
  logic             vs_c;

  // Framebuffer ports
  logic             wr_ok_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [2:0]       mem_q [FB_DEPTH];
  logic [2:0]       rd_data_q;

  // Stage 1 (aligned with the RAM read) and stage 2 (outputs)
  logic             hs1_q, hs1_d;
  logic             vs1_q, vs1_d;
  logic             blank1_q, blank1_d;
  logic             hs2_q, hs2_d;
  logic             vs2_q, vs2_d;
  logic             blank2_q, blank2_d;
  logic [7:0]       r2_q, r2_d;
  logic [7:0]       g2_q, g2_d;
  logic [7:0]       b2_q, b2_d;

  // Scan counters advance on pix_en; frame_start marks the step to (0,0)
  always_comb begin
    pix_en_d      = ~pix_en_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (pix_en_q) begin
      if (h_cnt_q == H_W'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_W'(V_TOTAL - 1)) begin
          v_cnt_d       = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + V_W'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + H_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_en_q      <= 1'b0;
      vga_clk_q     <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pix_en_q      <= pix_en_d;
      vga_clk_q     <= pix_en_q;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Visible window and sync decode from the current counters
  always_comb begin
    vis_c = (h_cnt_q < H_W'(H_VIS)) && (v_cnt_q < V_W'(V_VIS));
    hs_c  = !((h_cnt_q >= H_W'(HS_START)) && (h_cnt_q < H_W'(HS_END)));
    vs_c  = !((v_cnt_q >= V_W'(VS_START)) && (v_cnt_q < V_W'(VS_END)));
  end

  // Read address; parked at 0 outside the visible window (data is masked there)
  always_comb begin
    rd_addr_c = '0;
    if (vis_c) begin
      rd_addr_c = ADDR_W'(v_cnt_q >> SCALE_SHIFT) * ADDR_W'(FB_W)
                + ADDR_W'(h_cnt_q >> SCALE_SHIFT);
    end
  end

  // Write decode; out-of-range coordinates are dropped
  always_comb begin
    wr_ok_c   = wr.writeEn && (32'(wr.x) < FB_W) && (32'(wr.y) < FB_H);
    wr_addr_c = ADDR_W'(wr.y) * ADDR_W'(FB_W) + ADDR_W'(wr.x);
  end

  // Framebuffer write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem_q[wr_addr_c] <= wr.colour;
    end
  end

  // Registered read port; same-edge write is not seen (read-before-write)
  always_ff @(posedge clk) begin
    if (pix_en_q) begin
      rd_data_q <= mem_q[rd_addr_c];
    end
  end

  // Stage 1: syncs/blank follow the RAM read so data and timing stay aligned
  always_comb begin
    hs1_d    = hs1_q;
    vs1_d    = vs1_q;
    blank1_d = blank1_q;
    if (pix_en_q) begin
      hs1_d    = hs_c;
      vs1_d    = vs_c;
      blank1_d = vis_c;
    end
  end

  // Stage 2: colour bit expansion with blanking mask
  always_comb begin
    hs2_d    = hs2_q;
    vs2_d    = vs2_q;
    blank2_d = blank2_q;
    r2_d     = r2_q;
    g2_d     = g2_q;
    b2_d     = b2_q;
    if (pix_en_q) begin
      hs2_d    = hs1_q;
      vs2_d    = vs1_q;
      blank2_d = blank1_q;
      r2_d     = (blank1_q && rd_data_q[2]) ? 8'hFF : 8'h00;
      g2_d     = (blank1_q && rd_data_q[1]) ? 8'hFF : 8'h00;
      b2_d     = (blank1_q && rd_data_q[0]) ? 8'hFF : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      blank1_q <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      blank2_q <= 1'b0;
      r2_q     <= 8'h00;
      g2_q     <= 8'h00;
      b2_q     <= 8'h00;
    end else begin
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      blank1_q <= blank1_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      blank2_q <= blank2_d;
      r2_q     <= r2_d;
      g2_q     <= g2_d;
      b2_q     <= b2_d;
    end
  end

  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_BLANK_N = blank2_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r2_q;
  assign VGA_G       = g2_q;
  assign VGA_B       = b2_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_sink.sv
// tb_vga_frame_sink: directed bench for vga_frame_sink on a reduced screen
// geometry (8x6 framebuffer, 4x scale, 48x30 total, 2880 clk per frame).
module tb_vga_frame_sink;

  localparam int unsigned FB_W      = 8;
  localparam int unsigned FB_H      = 6;
  localparam int unsigned HT        = 48;    // 32 + 4 + 8 + 4
  localparam int unsigned FRAME_CLK = 2880;  // 48 * 30 * 2

  logic       clk = 1'b0;
  logic       reset;
  logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  vga_frame_sink_if wr_if ();

  vga_frame_sink #(
    .FB_W(FB_W), .FB_H(FB_H), .SCALE_SHIFT(2),
    .H_VIS(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(24), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr_if),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cur_off  = 0;   // negedges since the frame_start sample
  logic [24:0] px;             // {R,G,B,BLANK_N}
  logic [5:0]  ctl;            // {VGA_CLK,HS,VS,BLANK_N,SYNC_N,frame_start}

  localparam logic [24:0] PX_RED   = {8'hFF, 8'h00, 8'h00, 1'b1};
  localparam logic [24:0] PX_CYAN  = {8'h00, 8'hFF, 8'hFF, 1'b1};
  localparam logic [24:0] PX_WHITE = {8'hFF, 8'hFF, 8'hFF, 1'b1};
  localparam logic [24:0] PX_MAG   = {8'hFF, 8'h00, 8'hFF, 1'b1};
  localparam logic [24:0] PX_GREEN = {8'h00, 8'hFF, 8'h00, 1'b1};
  localparam logic [24:0] PX_BLACK = {8'h00, 8'h00, 8'h00, 1'b1};
  localparam logic [24:0] PX_OFF   = {8'h00, 8'h00, 8'h00, 1'b0};
  localparam logic [5:0]  CTL_RST  = 6'b011000;

  task automatic write_px(input int x, input int y, input logic [2:0] c);
    @(negedge clk);
    wr_if.x       = 8'(x);
    wr_if.y       = 7'(y);
    wr_if.colour  = c;
    wr_if.writeEn = 1'b1;
    @(negedge clk);
    wr_if.writeEn = 1'b0;
  endtask

  // Align to the negedge right after frame_start is seen high
  task automatic sync_frame();
    int n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (frame_start !== 1'b1) begin
      n_checks++;
      $display("FAIL frame_sync_timeout got=%b exp=1 after %0d clk", frame_start, n);
    end
    cur_off = 0;
  endtask

  task automatic advance_off(input int off);
    repeat (off - cur_off) @(negedge clk);
    cur_off = off;
  endtask

  // Output for screen (h,v) is stable from 2*(v*HT+h)+4 clk after frame_start
  task automatic advance_to(input int h, input int v);
    advance_off(2 * (v * int'(HT) + h) + 4);
    px = {VGA_R, VGA_G, VGA_B, VGA_BLANK_N};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_if.x       = 8'($urandom);
      wr_if.y       = 7'($urandom);
      wr_if.colour  = 3'($urandom);
      wr_if.writeEn = 1'($urandom);
      ctl = {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start};
      if (i == 2 || i == 5) begin
        n_checks++;
        if (ctl !== CTL_RST) $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_RST);
        else n_pass++;
        n_checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h0)
          $display("FAIL reset_rgb got=%h exp=000000", {VGA_R, VGA_G, VGA_B});
        else n_pass++;
      end
    end
    @(negedge clk);
    wr_if.writeEn = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (VGA_CLK !== 1'b0) $display("FAIL vga_clk_edge1 got=%b exp=0", VGA_CLK);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (VGA_CLK !== 1'b1) $display("FAIL vga_clk_edge2 got=%b exp=1", VGA_CLK);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (VGA_CLK !== 1'b0) $display("FAIL vga_clk_edge3 got=%b exp=0", VGA_CLK);
    else n_pass++;
  endtask

  task automatic clear_fb();
    for (int y = 0; y < int'(FB_H); y++)
      for (int x = 0; x < int'(FB_W); x++)
        write_px(x, y, 3'b000);
  endtask

  task automatic test_basic_write();
    write_px(0, 0, 3'b100);
    write_px(7, 5, 3'b011);
    write_px(2, 2, 3'b101);
    sync_frame();
    advance_to(0, 0);
    n_checks++;
    if (px !== PX_RED) $display("FAIL basic_00 got=%h exp=%h", px, PX_RED); else n_pass++;
    advance_to(3, 0);
    n_checks++;
    if (px !== PX_RED) $display("FAIL basic_30 got=%h exp=%h", px, PX_RED); else n_pass++;
    advance_to(4, 0);
    n_checks++;
    if (px !== PX_BLACK) $display("FAIL basic_40 got=%h exp=%h", px, PX_BLACK); else n_pass++;
    advance_to(3, 3);
    n_checks++;
    if (px !== PX_RED) $display("FAIL basic_33 got=%h exp=%h", px, PX_RED); else n_pass++;
    advance_to(28, 20);
    n_checks++;
    if (px !== PX_CYAN) $display("FAIL basic_28_20 got=%h exp=%h", px, PX_CYAN); else n_pass++;
    advance_to(27, 23);
    n_checks++;
    if (px !== PX_BLACK) $display("FAIL basic_27_23 got=%h exp=%h", px, PX_BLACK); else n_pass++;
    advance_to(31, 23);
    n_checks++;
    if (px !== PX_CYAN) $display("FAIL basic_31_23 got=%h exp=%h", px, PX_CYAN); else n_pass++;
  endtask

  task automatic test_out_of_range();
    write_px(0, 1, 3'b111);
    write_px(8, 0, 3'b001);     // would alias (0,1) if not dropped
    write_px(0, 6, 3'b010);
    write_px(160, 0, 3'b001);   // would alias (0,4) if not dropped
    write_px(0, 120, 3'b010);   // would alias (0,0) if not dropped
    sync_frame();
    advance_to(0, 0);
    n_checks++;
    if (px !== PX_RED) $display("FAIL oor_00 got=%h exp=%h", px, PX_RED); else n_pass++;
    advance_to(0, 4);
    n_checks++;
    if (px !== PX_WHITE) $display("FAIL oor_0_4 got=%h exp=%h", px, PX_WHITE); else n_pass++;
    advance_to(3, 7);
    n_checks++;
    if (px !== PX_WHITE) $display("FAIL oor_3_7 got=%h exp=%h", px, PX_WHITE); else n_pass++;
    advance_to(0, 16);
    n_checks++;
    if (px !== PX_BLACK) $display("FAIL oor_0_16 got=%h exp=%h", px, PX_BLACK); else n_pass++;
    advance_to(28, 20);
    n_checks++;
    if (px !== PX_CYAN) $display("FAIL oor_28_20 got=%h exp=%h", px, PX_CYAN); else n_pass++;
  endtask

  task automatic test_sync_timing();
    int n;
    sync_frame();
    advance_to(31, 0);
    n_checks++;
    if (VGA_BLANK_N !== 1'b1) $display("FAIL sync_blank_31 got=%b exp=1", VGA_BLANK_N); else n_pass++;
    advance_to(32, 0);
    n_checks++;
    if ({px, VGA_HS} !== {PX_OFF, 1'b1})
      $display("FAIL sync_blank_fall got=%h exp=%h", {px, VGA_HS}, {PX_OFF, 1'b1});
    else n_pass++;
    advance_to(35, 0);
    n_checks++;
    if (VGA_HS !== 1'b1) $display("FAIL sync_hs_35 got=%b exp=1", VGA_HS); else n_pass++;
    advance_to(36, 0);
    n_checks++;
    if (VGA_HS !== 1'b0) $display("FAIL sync_hs_36 got=%b exp=0", VGA_HS); else n_pass++;
    advance_to(43, 0);
    n_checks++;
    if (VGA_HS !== 1'b0) $display("FAIL sync_hs_43 got=%b exp=0", VGA_HS); else n_pass++;
    advance_to(44, 0);
    n_checks++;
    if (VGA_HS !== 1'b1) $display("FAIL sync_hs_44 got=%b exp=1", VGA_HS); else n_pass++;
    advance_to(0, 24);
    n_checks++;
    if ({VGA_BLANK_N, VGA_VS} !== 2'b01)
      $display("FAIL sync_v24 got=%b exp=01", {VGA_BLANK_N, VGA_VS});
    else n_pass++;
    advance_to(47, 25);
    n_checks++;
    if (VGA_VS !== 1'b1) $display("FAIL sync_vs_25 got=%b exp=1", VGA_VS); else n_pass++;
    advance_to(0, 26);
    n_checks++;
    if (VGA_VS !== 1'b0) $display("FAIL sync_vs_26 got=%b exp=0", VGA_VS); else n_pass++;
    advance_to(47, 27);
    n_checks++;
    if (VGA_VS !== 1'b0) $display("FAIL sync_vs_27 got=%b exp=0", VGA_VS); else n_pass++;
    advance_to(0, 28);
    n_checks++;
    if (VGA_VS !== 1'b1) $display("FAIL sync_vs_28 got=%b exp=1", VGA_VS); else n_pass++;
    sync_frame();
    @(negedge clk);
    n_checks++;
    if (frame_start !== 1'b0) $display("FAIL frame_start_width got=%b exp=0", frame_start); else n_pass++;
    n = 1;
    while (frame_start !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != int'(FRAME_CLK)) $display("FAIL frame_period got=%0d exp=%0d", n, FRAME_CLK);
    else n_pass++;
  endtask

  task automatic test_collision();
    sync_frame();
    // fb(2,2) is first read for screen (8,8) on the edge 786 clk after frame_start
    advance_off(785);
    wr_if.x       = 8'd2;
    wr_if.y       = 7'd2;
    wr_if.colour  = 3'b010;
    wr_if.writeEn = 1'b1;
    advance_off(786);
    wr_if.writeEn = 1'b0;
    advance_to(8, 8);
    n_checks++;
    if (px !== PX_MAG) $display("FAIL collide_old got=%h exp=%h", px, PX_MAG); else n_pass++;
    advance_to(9, 8);
    n_checks++;
    if (px !== PX_GREEN) $display("FAIL collide_next_px got=%h exp=%h", px, PX_GREEN); else n_pass++;
    sync_frame();
    advance_to(8, 8);
    n_checks++;
    if (px !== PX_GREEN) $display("FAIL collide_next_frame got=%h exp=%h", px, PX_GREEN); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int n;
    sync_frame();
    advance_to(8, 10);
    n_checks++;
    if (px !== PX_GREEN) $display("FAIL midrst_pre got=%h exp=%h", px, PX_GREEN); else n_pass++;
    reset = 1'b0;
    #1;
    ctl = {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start};
    n_checks++;
    if (ctl !== CTL_RST) $display("FAIL midrst_ctl got=%b exp=%b", ctl, CTL_RST); else n_pass++;
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0)
      $display("FAIL midrst_rgb got=%h exp=000000", {VGA_R, VGA_G, VGA_B});
    else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (frame_start !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != int'(FRAME_CLK)) $display("FAIL midrst_first_frame got=%0d exp=%0d", n, FRAME_CLK);
    else n_pass++;
    cur_off = 0;
    advance_to(0, 0);
    n_checks++;
    if (px !== PX_RED) $display("FAIL midrst_keep_00 got=%h exp=%h", px, PX_RED); else n_pass++;
    advance_to(0, 4);
    n_checks++;
    if (px !== PX_WHITE) $display("FAIL midrst_keep_0_4 got=%h exp=%h", px, PX_WHITE); else n_pass++;
    advance_to(8, 8);
    n_checks++;
    if (px !== PX_GREEN) $display("FAIL midrst_keep_8_8 got=%h exp=%h", px, PX_GREEN); else n_pass++;
  endtask

  initial begin
    wr_if.x       = 8'd0;
    wr_if.y       = 7'd0;
    wr_if.colour  = 3'd0;
    wr_if.writeEn = 1'b0;
    test_reset();
    clear_fb();
    test_basic_write();
    test_out_of_range();
    test_sync_timing();
    test_collision();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
